// File: rtl/ir_tx_scheduler.sv
// Key arbiter and NEC frame/repeat sequencer in front of ir_encoder.
// Round-robin over latched key presses; repeat codes while the key is held.
module ir_tx_scheduler #(
  parameter int unsigned REPEAT_CYC = 2_700_000,
  parameter logic [31:0] CMD0 = 32'b10011101011000100000011100000111,
  parameter logic [31:0] CMD1 = 32'b10011111011000000000011100000111,
  parameter logic [31:0] CMD2 = 32'b10011110011000010000011100000111,
  parameter logic [31:0] CMD3 = 32'b10011010011001010000011100000111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_state,
  input  logic        enc_ready,
  output logic        enc_valid,
  output logic [31:0] enc_cmd,
  output logic        enc_repeat,
  output logic [1:0]  active_id,
  output logic        busy
);

  localparam logic [23:0] TMAX = 24'(REPEAT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_FRAME,
    WAIT_DONE,
    HOLD,
    SEND_REPEAT
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  prev_q;
  logic [3:0]  pend_q, pend_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  act_q, act_d;
  logic [31:0] cmd_q, cmd_d;
  logic        vld_q, vld_d;
  logic        rep_q, rep_d;
  logic        busy_q, busy_d;
  logic        first_q, first_d;
  logic [23:0] tmr_q, tmr_d;

  logic        gnt_any;
  logic [1:0]  gnt_id;
  logic [1:0]  idx;
  logic [3:0]  gnt_mask;
  logic        hs;

  // Search starts one past the last winner so every key gets a turn
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = last_q;
    idx     = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!gnt_any && pend_q[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  function automatic logic [31:0] cmd_of(input logic [1:0] id);
    logic [31:0] c;
    c = CMD0;
    unique case (1'b1)
      (id == 2'd0): c = CMD0;
      (id == 2'd1): c = CMD1;
      (id == 2'd2): c = CMD2;
      (id == 2'd3): c = CMD3;
      default:      c = CMD0;
    endcase
    return c;
  endfunction

  always_comb begin
    hs       = vld_q & enc_ready;
    gnt_mask = 4'b0000;
    state_d  = state_q;
    last_d   = last_q;
    act_d    = act_q;
    cmd_d    = cmd_q;
    vld_d    = vld_q;
    rep_d    = rep_q;
    first_d  = 1'b0;
    if (hs)
      tmr_d = '0;
    else if (tmr_q < TMAX)
      tmr_d = tmr_q + 24'd1;
    else
      tmr_d = tmr_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          gnt_mask[gnt_id] = 1'b1;
          state_d = SEND_FRAME;
          vld_d   = 1'b1;
          rep_d   = 1'b0;
          act_d   = gnt_id;
          last_d  = gnt_id;
          cmd_d   = cmd_of(gnt_id);
        end
      end
      SEND_FRAME, SEND_REPEAT: begin
        if (hs) begin
          vld_d   = 1'b0;
          first_d = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // enc_ready may still be stale in the cycle right after a handshake
        if (!first_q && enc_ready)
          state_d = req_state[act_q] ? HOLD : IDLE;
      end
      HOLD: begin
        if (!req_state[act_q]) begin
          state_d = IDLE;
        end else if (tmr_q >= TMAX) begin
          state_d = SEND_REPEAT;
          vld_d   = 1'b1;
          rep_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    pend_d = (pend_q & ~gnt_mask) | (req_state & ~prev_q);
    busy_d = (state_d != IDLE) | (|pend_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= 4'b1111;
      pend_q  <= '0;
      last_q  <= 2'd3;
      act_q   <= '0;
      cmd_q   <= '0;
      vld_q   <= 1'b0;
      rep_q   <= 1'b0;
      busy_q  <= 1'b0;
      first_q <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= req_state;
      pend_q  <= pend_d;
      last_q  <= last_d;
      act_q   <= act_d;
      cmd_q   <= cmd_d;
      vld_q   <= vld_d;
      rep_q   <= rep_d;
      busy_q  <= busy_d;
      first_q <= first_d;
      tmr_q   <= tmr_d;
    end
  end

  assign enc_valid  = vld_q;
  assign enc_cmd    = cmd_q;
  assign enc_repeat = rep_q;
  assign active_id  = act_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Directed bench for ir_tx_scheduler with a simple encoder-ready model.
// Handshakes are logged on the falling edge and checked against hand values.
module tb_ir_tx_scheduler;

  localparam int RC = 100;
  localparam logic [31:0] C0 = 32'b10011101011000100000011100000111;
  localparam logic [31:0] C1 = 32'b10011111011000000000011100000111;
  localparam logic [31:0] C2 = 32'b10011110011000010000011100000111;
  localparam logic [31:0] C3 = 32'b10011010011001010000011100000111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_state = 4'b0000;
  logic        enc_ready;
  logic        enc_valid;
  logic [31:0] enc_cmd;
  logic        enc_repeat;
  logic [1:0]  active_id;
  logic        busy;

  ir_tx_scheduler #(.REPEAT_CYC(RC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_state  (req_state),
    .enc_ready  (enc_ready),
    .enc_valid  (enc_valid),
    .enc_cmd    (enc_cmd),
    .enc_repeat (enc_repeat),
    .active_id  (active_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Encoder model: busy for 20 cycles after every accepted request
  logic [7:0] rcnt = 8'd0;
  logic       hold_low = 1'b0;
  assign enc_ready = (rcnt == 8'd0) && !hold_low;

  always @(posedge clk) begin
    if (enc_valid && enc_ready)
      rcnt <= 8'd20;
    else if (rcnt != 8'd0)
      rcnt <= rcnt - 8'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] lg_cmd[$];
  bit          lg_rep[$];
  logic [1:0]  lg_id[$];
  int          lg_cyc[$];

  logic        pv = 1'b0;
  logic        phs = 1'b0;
  logic        prep = 1'b0;
  logic [31:0] pcmd = '0;
  int          viol = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv  <= 1'b0;
      phs <= 1'b0;
    end else begin
      if (pv && !phs &&
          (!enc_valid || enc_cmd !== pcmd || enc_repeat !== prep))
        viol <= viol + 1;
      if (enc_valid && enc_ready) begin
        lg_cmd.push_back(enc_cmd);
        lg_rep.push_back(enc_repeat);
        lg_id.push_back(active_id);
        lg_cyc.push_back(cyc);
      end
      pv   <= enc_valid;
      phs  <= enc_valid && enc_ready;
      pcmd <= enc_cmd;
      prep <= enc_repeat;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n0;
  int sp;

  initial begin
    step(2);
    chk("rst_valid", 32'(enc_valid), 0);
    chk("rst_repeat", 32'(enc_repeat), 0);
    chk("rst_cmd", enc_cmd, 0);
    chk("rst_id", 32'(active_id), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step(3);

    // single press of key 1, released while the frame is still pending
    hold_low  = 1'b1;
    n0        = lg_cmd.size();
    req_state = 4'b0010;
    step(1);
    chk("t1_lat1", 32'(enc_valid), 0);
    step(1);
    chk("t1_lat2", 32'(enc_valid), 1);
    chk("t1_cmd", enc_cmd, C1);
    chk("t1_rep", 32'(enc_repeat), 0);
    chk("t1_id", 32'(active_id), 1);
    chk("t1_busy", 32'(busy), 1);
    step(8);
    req_state = 4'b0000;
    step(5);
    chk("t1_vhold", 32'(enc_valid), 1);
    chk("t1_nohs", 32'(lg_cmd.size() - n0), 0);
    hold_low = 1'b0;
    step(60);
    chk("t1_cnt", 32'(lg_cmd.size() - n0), 1);
    chk("t1_lcmd", lg_cmd[n0], C1);
    chk("t1_lrep", 32'(lg_rep[n0]), 0);
    chk("t1_lid", 32'(lg_id[n0]), 1);
    chk("t1_idle", 32'(busy), 0);

    // key 0 held 350 cycles: frame plus three repeats
    n0        = lg_cmd.size();
    req_state = 4'b0001;
    step(350);
    req_state = 4'b0000;
    step(150);
    chk("t2_cnt", 32'(lg_cmd.size() - n0), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_cmd", lg_cmd[n0 + k], C0);
      chk("t2_rep", 32'(lg_rep[n0 + k]), (k == 0) ? 0 : 1);
    end
    for (int k = 2; k < 4; k++) begin
      sp = lg_cyc[n0 + k] - lg_cyc[n0 + k - 1];
      chk("t2_space", 32'(sp >= RC), 1);
    end
    chk("t2_idle", 32'(busy), 0);

    // simultaneous presses after reset: 0, 2, 3 then 1
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    n0        = lg_cmd.size();
    req_state = 4'b1101;
    step(5);
    req_state = 4'b0000;
    step(200);
    chk("t3_cnt", 32'(lg_cmd.size() - n0), 3);
    chk("t3_o0", lg_cmd[n0], C0);
    chk("t3_o1", lg_cmd[n0 + 1], C2);
    chk("t3_o2", lg_cmd[n0 + 2], C3);
    req_state = 4'b0010;
    step(5);
    req_state = 4'b0000;
    step(60);
    chk("t3_cnt1", 32'(lg_cmd.size() - n0), 4);
    chk("t3_k1", lg_cmd[n0 + 3], C1);
    chk("t3_id1", 32'(lg_id[n0 + 3]), 1);

    // key 2 pressed while key 0 sits in HOLD
    n0        = lg_cmd.size();
    req_state = 4'b0001;
    step(50);
    req_state = 4'b0101;
    step(40);
    chk("t4_only0", 32'(lg_cmd.size() - n0), 1);
    chk("t4_cmd0", lg_cmd[n0], C0);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_novld", 32'(enc_valid), 0);
    req_state = 4'b0100;
    step(1);
    chk("t4_idle", 32'(enc_valid), 0);
    step(1);
    chk("t4_vld", 32'(enc_valid), 1);
    chk("t4_cmd2", enc_cmd, C2);
    chk("t4_id2", 32'(active_id), 2);
    chk("t4_rep", 32'(enc_repeat), 0);
    req_state = 4'b0000;
    step(60);
    chk("t4_cnt", 32'(lg_cmd.size() - n0), 2);
    chk("t4_done", 32'(busy), 0);

    // encoder stalled 300 cycles after a frame with key 3 held
    n0        = lg_cmd.size();
    req_state = 4'b1000;
    step(3);
    hold_low = 1'b1;
    step(300);
    chk("t5_frame", 32'(lg_cmd.size() - n0), 1);
    chk("t5_novld", 32'(enc_valid), 0);
    hold_low = 1'b0;
    step(10);
    chk("t5_one", 32'(lg_cmd.size() - n0), 2);
    chk("t5_rep", 32'(lg_rep[n0 + 1]), 1);
    chk("t5_cmd", lg_cmd[n0 + 1], C3);
    req_state = 4'b0000;
    step(60);
    chk("t5_cnt", 32'(lg_cmd.size() - n0), 2);
    chk("t5_idle", 32'(busy), 0);

    // reset while a repeat waits for the encoder
    n0        = lg_cmd.size();
    req_state = 4'b0001;
    step(60);
    hold_low = 1'b1;
    step(60);
    chk("t6_vld", 32'(enc_valid), 1);
    chk("t6_rep", 32'(enc_repeat), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rvld", 32'(enc_valid), 0);
    chk("t6_rrep", 32'(enc_repeat), 0);
    chk("t6_rcmd", enc_cmd, 0);
    chk("t6_rid", 32'(active_id), 0);
    chk("t6_rbusy", 32'(busy), 0);
    step(2);
    hold_low = 1'b0;
    rst_n    = 1'b1;
    step(50);
    chk("t6_nosend", 32'(lg_cmd.size() - n0), 1);
    chk("t6_quiet", 32'(enc_valid), 0);
    chk("t6_nbusy", 32'(busy), 0);
    req_state = 4'b0000;
    step(2);
    req_state = 4'b0001;
    step(2);
    chk("t6_fvld", 32'(enc_valid), 1);
    chk("t6_fcmd", enc_cmd, C0);
    chk("t6_frep", 32'(enc_repeat), 0);
    req_state = 4'b0000;
    step(60);
    chk("t6_cnt", 32'(lg_cmd.size() - n0), 2);

    chk("stable", 32'(viol), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
